twitch_core: RTL and testbench
==============================

Name: twitch_core

Overview:
- Minimal multi-cycle RV32I processor core with a private unified instruction/data RAM.
- Executes firmware preloaded into the RAM by a hex image.
- Runs until it hits ECALL/EBREAK, then raises `trap` and halts.
- Top-level CPU for bring-up and compliance runs; pass/fail is read from x3 (gp) after the trap.

Parameters:
- MEM_WORDS, 16384, RAM depth in 32-bit words (64 KiB).
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- resetn  input  1  asynchronous active-low reset.
- trap  output  1  high once ECALL/EBREAK retires; sticky until reset.

Behaviour:
- Reset, while resetn=0:
  - pc=RESET_PC, step=7'b0000001, trap=0, pend=0, d_addr=0, d_data=0.
  - regs[1..31]=0; RAM contents untouched.
- Debug visibility: these internal names must exist hierarchically and be readable by the bench:
  - step[6:0], pc[31:0], i_data[31:0], opcode[6:0], alu_func[2:0], alu_alt (instr[30]).
  - alu_left[31:0] (rs1 value or pc), alu_imm[31:0] (decoded sign-extended immediate).
  - pend[31:0] (result pending writeback), d_addr[31:0], d_data[31:0].
  - regs[0:31][31:0], RAM instance `r` with array `mem[0:MEM_WORDS-1][31:0]`.
- RAM addressing: word index = addr[log2(MEM_WORDS)+1:2]; upper address bits ignored.
- RAM timing: synchronous read (1-cycle latency); write with 4-bit byte enables.
- Sequencer: one-hot step, exactly one bit set, advances one bit per clock. Every instruction takes 7 cycles:
  - step0: issue fetch at pc.
  - step1: latch i_data; decode opcode/alu_func/alu_alt/alu_imm.
  - step2: read rs1/rs2; form alu_left.
  - step3: execute: ALU result into pend; branch compare; compute d_addr=rs1+imm.
  - step4: issue load read or store write. Store data is shifted into byte lanes and written with byte enables SB/SH/SW by d_addr[1:0].
  - step5: capture load data into d_data; extract and sign/zero-extend LB/LH/LW/LBU/LHU. Misaligned half/word accesses align down.
  - step6: write rd (x0 never written); update pc; wrap step to step0.
- PC update:
  - Default pc+4.
  - Taken branch: pc+imm.
  - JAL: pc+imm.
  - JALR: (rs1+imm)&~1.
  - JAL/JALR write pc+4 to rd.
- Instruction coverage:
  - Full RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, loads, stores, OP-IMM, OP (incl. SUB/SRA via alu_alt).
  - Shift amount uses low 5 bits.
  - FENCE = NOP.
  - CSR* instructions write 0 to rd, no other effect.
  - Unknown opcode = NOP.
- ECALL/EBREAK: at step6, trap goes high and the sequencer freezes (step stays 0). No further writes until reset.
- Async reset mid-instruction aborts it; no partial register write survives.
- Arithmetic: 32-bit wrap-around; SLT signed, SLTU unsigned.

Decomposition:
- Shared package twitch_core_pkg:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM).
  - funct3 ALU codes (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND).
  - step index constants.
- One natural sub-module: twitch_core_ram (instance `r`). Dual-port: instruction read port and data read/write port with byte enables.
- ALU and decode stay inline in the core.

Test Plan:
- ADDI x3,x0,1; ECALL at RESET_PC -> trap rises on cycle 14 after reset release; regs[3]=1; pc stays 0x80000004.
- LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,0x100(x0); LB x2,0x101(x0); LBU x4,0x103(x0) -> mem[0x40]=0x12345678, x2=0x00000056, x4=0x00000012.
- ADDI x1,x0,-1; SRLI x2,x1,4; SRAI x4,x1,4; SLTU x5,x0,x1; SLT x6,x0,x1 -> x2=0x0FFFFFFF, x4=0xFFFFFFFF, x5=1, x6=0.
- Branch loop: x1=3, decrement, BNE x1,x0,-4 -> loop body retires 3 times, x1=0, fall-through to next instruction.
- JAL x1,+8 then JALR x0,0(x1) -> x1=pc_jal+4, control returns to pc_jal+4; ADDI x0,x0,5 leaves x0=0.
- Assert resetn low during step3 of a store -> memory unchanged, pc=RESET_PC, step=0000001, trap=0.

Source files
------------

// File: rtl/twitch_core_pkg.sv
// twitch_core_pkg: shared opcodes, ALU function codes, sequencer step indices and immediate decode
package twitch_core_pkg;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam int S_FETCH = 0;
    localparam int S_DEC   = 1;
    localparam int S_REG   = 2;
    localparam int S_EXE   = 3;
    localparam int S_MEM   = 4;
    localparam int S_LD    = 5;
    localparam int S_WB    = 6;

    function automatic logic [31:0] imm_decode(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (op == OP_LUI || op == OP_AUIPC) ? {ins[31:12], 12'h000} :
               (op == OP_JAL)    ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
               (op == OP_BRANCH) ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
               (op == OP_STORE)  ? {{21{ins[31]}}, ins[30:25], ins[11:7]} :
                                   {{21{ins[31]}}, ins[30:20]};
    endfunction
endpackage

// File: rtl/twitch_core_ram.sv
// twitch_core_ram: unified word RAM with a fetch read port and a byte-enabled data port
module twitch_core_ram #(
    parameter int MEM_WORDS = 16384,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_iaddr,
    output logic [31:0]   o_idata,
    input  logic [AW-1:0] i_daddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_be,
    output logic [31:0]   o_drdata
);
    logic [31:0] mem [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
        o_idata  <= mem[i_iaddr];
        o_drdata <= mem[i_daddr];
        for (int b = 0; b < 4; b++)
            if (i_be[b]) mem[i_daddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
endmodule

// File: rtl/twitch_core.sv
// twitch_core: seven-step multi-cycle RV32I core that halts with a sticky trap on ECALL/EBREAK
module twitch_core
    import twitch_core_pkg::*;
#(
    parameter int          MEM_WORDS = 16384,
    parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
    input  logic clk,
    input  logic resetn,
    output logic trap
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [6:0]  step;
    logic [31:0] pc, i_data, alu_left, pend, d_addr, d_data, r_rs2;
    logic [31:0] regs [0:31];
    logic        r_taken;
    logic [6:0]  opcode;
    logic [2:0]  alu_func;
    logic        alu_alt;
    logic [31:0] alu_imm;
    logic [31:0] w_idata, w_drdata, w_b, w_alu, w_sra, w_res, w_load, w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;
    logic        w_sub, w_cmp, w_ecall, w_wr_rd;

    twitch_core_ram #(.MEM_WORDS(MEM_WORDS)) r (
        .clk     (clk),
        .i_iaddr (pc[AW+1:2]),
        .o_idata (w_idata),
        .i_daddr (d_addr[AW+1:2]),
        .i_wdata (w_wdata),
        .i_be    (w_be),
        .o_drdata(w_drdata)
    );

    assign opcode   = i_data[6:0];
    assign alu_func = i_data[14:12];
    assign alu_alt  = i_data[30];
    assign alu_imm  = imm_decode(i_data);

    // only register-register ops subtract; ADDI with a negative immediate also has bit 30 set
    assign w_b   = (opcode == OP_REG) ? r_rs2 : alu_imm;
    assign w_sub = (opcode == OP_REG) && alu_alt;
    assign w_sra = $signed(alu_left) >>> w_b[4:0];

    always_comb begin
        w_alu = w_sub ? alu_left - w_b : alu_left + w_b;
        case (alu_func)
            F3_SLL:  w_alu = alu_left << w_b[4:0];
            F3_SLT:  w_alu = {31'd0, $signed(alu_left) < $signed(w_b)};
            F3_SLTU: w_alu = {31'd0, alu_left < w_b};
            F3_XOR:  w_alu = alu_left ^ w_b;
            F3_SR:   w_alu = alu_alt ? w_sra : alu_left >> w_b[4:0];
            F3_OR:   w_alu = alu_left | w_b;
            F3_AND:  w_alu = alu_left & w_b;
            default: ;
        endcase
    end

    assign w_res = (opcode == OP_LUI)   ? alu_imm :
                   (opcode == OP_AUIPC) ? alu_left + alu_imm :
                   (opcode == OP_JAL || opcode == OP_JALR) ? pc + 32'd4 :
                   (opcode == OP_SYSTEM) ? 32'd0 : w_alu;

    assign w_cmp = ((alu_func[2:1] == 2'b00) ? (alu_left == r_rs2) :
                    (alu_func[2:1] == 2'b10) ? ($signed(alu_left) < $signed(r_rs2)) :
                                               (alu_left < r_rs2)) ^ alu_func[0];

    assign w_byte = w_drdata[{d_addr[1:0], 3'b000} +: 8];
    assign w_half = w_drdata[{d_addr[1], 4'b0000} +: 16];
    assign w_load = (alu_func[1:0] == 2'd0) ? {{24{~alu_func[2] & w_byte[7]}}, w_byte} :
                    (alu_func[1:0] == 2'd1) ? {{16{~alu_func[2] & w_half[15]}}, w_half} : w_drdata;

    assign w_wdata = (alu_func[1:0] == 2'd0) ? {4{r_rs2[7:0]}} :
                     (alu_func[1:0] == 2'd1) ? {2{r_rs2[15:0]}} : r_rs2;
    assign w_be = !(step[S_MEM] && opcode == OP_STORE) ? 4'b0000 :
                  (alu_func[1:0] == 2'd0) ? 4'b0001 << d_addr[1:0] :
                  (alu_func[1:0] == 2'd1) ? (d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign w_ecall = (opcode == OP_SYSTEM) && (alu_func == 3'd0);
    assign w_wr_rd = (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG, OP_SYSTEM})
                     && (i_data[11:7] != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step     <= 7'b0000001;
            pc       <= RESET_PC;
            trap     <= 1'b0;
            pend     <= '0;
            d_addr   <= '0;
            d_data   <= '0;
            i_data   <= '0;
            alu_left <= '0;
            r_rs2    <= '0;
            r_taken  <= 1'b0;
            for (int k = 0; k < 32; k++) regs[k] <= '0;
        end else if (!trap) begin
            step <= {step[5:0], step[6]};
            if (step[S_DEC]) i_data <= w_idata;
            if (step[S_REG]) begin
                alu_left <= (opcode == OP_AUIPC) ? pc : regs[i_data[19:15]];
                r_rs2    <= regs[i_data[24:20]];
            end
            if (step[S_EXE]) begin
                pend    <= w_res;
                r_taken <= (opcode == OP_BRANCH) && w_cmp;
                d_addr  <= alu_left + alu_imm;
            end
            if (step[S_LD]) d_data <= w_load;
            if (step[S_WB]) begin
                if (w_wr_rd) regs[i_data[11:7]] <= (opcode == OP_LOAD) ? d_data : pend;
                trap <= w_ecall;
                pc   <= w_ecall ? pc :
                        (opcode == OP_JALR) ? {d_addr[31:1], 1'b0} :
                        (opcode == OP_JAL || r_taken) ? pc + alu_imm : pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_twitch_core.sv
// tb_twitch_core: table-driven firmware runs with a scoreboard of expected architectural state
module tb_twitch_core;
    localparam logic [31:0] RPC   = 32'h8000_0000;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic trap;

    twitch_core dut (.clk(clk), .resetn(resetn), .trap(trap));

    always #5 clk = ~clk;

    typedef struct { logic [11:0][31:0] w; int n; } prog_t;
    typedef struct { int t; int kind; int idx; logic [31:0] exp; } chk_t;

    prog_t progs [1:6];
    chk_t  tab [$];
    chk_t  sb [$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic add(input int t, input logic [31:0] w);
        progs[t].w[progs[t].n] = w;
        progs[t].n++;
    endtask
    task automatic expect_(input int t, input int kind, input int idx, input logic [31:0] exp);
        tab.push_back('{t, kind, idx, exp});
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int kind, input int idx);
        return (kind == 0) ? dut.regs[idx] : (kind == 1) ? dut.r.mem[idx] :
               (kind == 2) ? dut.pc : 32'(cyc);
    endfunction
    function automatic string kname(input int kind);
        return (kind == 0) ? "x" : (kind == 1) ? "mem" : (kind == 2) ? "pc" : "cycles";
    endfunction

    task automatic load_and_reset(input int t);
        resetn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) dut.r.mem[i] = 32'h0;
        dut.r.mem[64] = 32'hDEAD_BEEF;
        for (int i = 0; i < progs[t].n; i++) dut.r.mem[i] = progs[t].w[i];
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic run_prog(input int t);
        chk_t c;
        load_and_reset(t);
        foreach (tab[k]) if (tab[k].t == t) sb.push_back(tab[k]);
        cyc = 0;
        while (trap !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("t%0d trap", t), 32'(trap), 32'd1);
        while (sb.size() > 0) begin
            c = sb.pop_front();
            check($sformatf("t%0d %s[%0d]", t, kname(c.kind), c.idx), actual(c.kind, c.idx), c.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int t = 1; t <= 6; t++) progs[t].n = 0;
        // kinds: 0 register, 1 RAM word, 2 pc at trap, 3 cycles from reset release to trap
        add(1, enc_i(1, 0, 0, 3, 7'h13)); add(1, ECALL);
        expect_(1, 0, 3, 32'd1); expect_(1, 2, 0, RPC + 32'd4); expect_(1, 3, 0, 32'd14);

        add(2, enc_u(32'h12345, 1, 7'h37));   add(2, enc_i(32'h678, 1, 0, 1, 7'h13));
        add(2, enc_s(32'h100, 1, 0, 2));      add(2, enc_i(32'h101, 0, 0, 2, 7'h03));
        add(2, enc_i(32'h103, 0, 4, 4, 7'h03)); add(2, enc_i(-128, 0, 0, 7, 7'h13));
        add(2, enc_s(32'h103, 7, 0, 0));      add(2, enc_i(32'h102, 0, 1, 8, 7'h03));
        add(2, enc_i(32'h103, 0, 5, 9, 7'h03)); add(2, enc_i(32'h103, 0, 0, 10, 7'h03));
        add(2, ECALL);
        expect_(2, 0, 2, 32'h0000_0056); expect_(2, 0, 4, 32'h0000_0012);
        expect_(2, 0, 8, 32'hFFFF_8034); expect_(2, 0, 9, 32'h0000_8034);
        expect_(2, 0, 10, 32'hFFFF_FF80); expect_(2, 1, 64, 32'h8034_5678);
        expect_(2, 2, 0, RPC + 32'd40); expect_(2, 3, 0, 32'd77);

        add(3, enc_i(-1, 0, 0, 1, 7'h13));    add(3, enc_i(4, 1, 5, 2, 7'h13));
        add(3, enc_i(32'h404, 1, 5, 4, 7'h13)); add(3, enc_r(0, 1, 0, 3, 5));
        add(3, enc_r(0, 1, 0, 2, 6));         add(3, enc_r(32'h20, 1, 0, 0, 7));
        add(3, enc_r(0, 1, 1, 1, 8));         add(3, ECALL);
        expect_(3, 0, 2, 32'h0FFF_FFFF); expect_(3, 0, 4, 32'hFFFF_FFFF);
        expect_(3, 0, 5, 32'd1); expect_(3, 0, 6, 32'd0); expect_(3, 0, 7, 32'd1);
        expect_(3, 0, 8, 32'h8000_0000); expect_(3, 3, 0, 32'd56);

        add(4, enc_i(3, 0, 0, 1, 7'h13));     add(4, enc_i(-1, 1, 0, 1, 7'h13));
        add(4, enc_i(1, 2, 0, 2, 7'h13));     add(4, enc_b(-8, 0, 1, 1));
        add(4, enc_i(7, 0, 0, 3, 7'h13));     add(4, enc_i(-1, 0, 0, 5, 7'h13));
        add(4, enc_b(8, 0, 5, 4));            add(4, enc_i(1, 0, 0, 6, 7'h13));
        add(4, enc_b(8, 0, 5, 6));            add(4, enc_i(1, 0, 0, 7, 7'h13));
        add(4, ECALL);
        expect_(4, 0, 1, 32'd0); expect_(4, 0, 2, 32'd3); expect_(4, 0, 3, 32'd7);
        expect_(4, 0, 6, 32'd0); expect_(4, 0, 7, 32'd1);
        expect_(4, 2, 0, RPC + 32'd40); expect_(4, 3, 0, 32'd112);

        add(5, enc_j(12, 1));                 add(5, enc_i(5, 0, 0, 0, 7'h13));
        add(5, ECALL);                        add(5, enc_u(1, 6, 7'h17));
        add(5, enc_i(5, 0, 0, 7, 7'h13));     add(5, enc_i(32'h300, 0, 2, 7, 7'h73));
        add(5, enc_i(1, 1, 0, 5, 7'h67));
        expect_(5, 0, 0, 32'd0); expect_(5, 0, 1, RPC + 32'd4); expect_(5, 0, 5, RPC + 32'h1C);
        expect_(5, 0, 6, 32'h8000_100C); expect_(5, 0, 7, 32'd0);
        expect_(5, 2, 0, RPC + 32'd8); expect_(5, 3, 0, 32'd49);

        add(6, enc_i(32'h55, 0, 0, 1, 7'h13)); add(6, enc_s(32'h100, 1, 0, 2)); add(6, ECALL);

        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", dut.pc, RPC);
        check("reset step", 32'(dut.step), 32'd1);
        check("reset trap", 32'(trap), 32'd0);
        check("reset pend", dut.pend, 32'd0);
        check("reset d_addr", dut.d_addr, 32'd0);
        check("reset d_data", dut.d_data, 32'd0);

        for (int t = 1; t <= 5; t++) run_prog(t);

        repeat (20) @(posedge clk);
        #1;
        check("sticky trap", 32'(trap), 32'd1);
        check("frozen pc", dut.pc, RPC + 32'd8);
        check("frozen step", 32'(dut.step), 32'd1);
        check("frozen x5", dut.regs[5], RPC + 32'h1C);

        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset pc", dut.pc, RPC);
        check("async reset trap", 32'(trap), 32'd0);
        check("async reset x5", dut.regs[5], 32'd0);

        load_and_reset(6);
        cyc = 0;
        while (!(dut.step == 7'b0001000 && dut.pc == RPC + 32'd4) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("store step3 reached", 32'(dut.step), 32'h08);
        #2;
        resetn = 1'b0;
        #1;
        check("abort pc", dut.pc, RPC);
        check("abort step", 32'(dut.step), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("abort mem", dut.r.mem[64], 32'hDEAD_BEEF);
        check("abort x1", dut.regs[1], 32'd0);
        check("abort trap", 32'(trap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
